// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store unit bus access controller with alignment, extension and timeout
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int             CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  LP_TMAX = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_flush_pend;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [31:0]   r_bus_addr;
    logic [3:0]    r_bus_wstrb;
    logic [31:0]   r_bus_wdata;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [1:0]    r_off;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [31:0]   r_resp_rdata;

    logic          w_misaligned;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_data;
    logic          w_drop_resp;

    always_comb begin
        w_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00));
        w_wstrb = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_wstrb = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset latched at accept, not the live request bus.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = bus_rdata;
        endcase
    end

    assign w_drop_resp = r_flush_pend || flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 32'h0;
            r_bus_wstrb  <= 4'h0;
            r_bus_wdata  <= 32'h0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_off        <= 2'b00;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_misaligned) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_state      <= S_BUSY;
                            r_cnt        <= '0;
                            r_flush_pend <= 1'b0;
                            r_bus_req    <= 1'b1;
                            r_bus_we     <= req_we;
                            r_bus_addr   <= {req_addr[31:2], 2'b00};
                            r_bus_wstrb  <= req_we ? w_wstrb : 4'h0;
                            r_bus_wdata  <= req_we ? w_wdata : 32'h0;
                            r_size       <= req_size;
                            r_unsigned   <= req_unsigned;
                            r_off        <= req_addr[1:0];
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    // An ack arriving on the last counted cycle still completes normally.
                    if (bus_ack) begin
                        r_state      <= S_RESP;
                        r_bus_req    <= 1'b0;
                        r_resp_valid <= !w_drop_resp;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_bus_we ? 32'h0 : w_load_data;
                    end else if (r_cnt == LP_TMAX) begin
                        r_state      <= S_RESP;
                        r_bus_req    <= 1'b0;
                        r_resp_valid <= !w_drop_resp;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_flush_pend <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign stall      = (r_state != S_IDLE);
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wstrb  = r_bus_wstrb;
    assign bus_wdata  = r_bus_wdata;
    // A flush seen during the response cycle itself suppresses the pulse.
    assign resp_valid = r_resp_valid && !flush;
    assign resp_err   = r_resp_err && resp_valid;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          k;
        logic [3:0]  strb;
        logic [31:0] bwdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                if (e.cyc >= 0) chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output int a);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_wait: got req_ready=0 expected 1 within 20 cycles");
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = cyc;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic ack_after(input int k, input logic [31:0] d);
        repeat (k) step();
        chk("bus_req_held", 32'(bus_req), 32'd1);
        bus_ack = 1'b1; bus_rdata = d;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        chk("bus_req_drop", 32'(bus_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        exp_t e;
        //            we    size   uns   addr          wdata         rdata         k  strb   bwdata        exp_rdata
        vt[0] = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2, 4'h0, 32'h0,        32'hFFFF_FF80};
        vt[1] = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 1, 4'hC, 32'hABCD_ABCD, 32'h0};
        vt[2] = '{1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0,        32'h80FF_1234, 0, 4'h0, 32'h0,        32'h0000_80FF};
        vt[3] = '{1'b0, 2'b01, 1'b0, 32'h0000_4000, 32'h0,        32'h1234_8001, 1, 4'h0, 32'h0,        32'hFFFF_8001};
        vt[4] = '{1'b0, 2'b00, 1'b1, 32'h0000_5001, 32'h0,        32'h0000_A500, 2, 4'h0, 32'h0,        32'h0000_00A5};
        vt[5] = '{1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h1234_5677, 32'h0,        0, 4'h2, 32'h7777_7777, 32'h0};
        vt[6] = '{1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,        1, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vt[7] = '{1'b0, 2'b11, 1'b0, 32'h0000_8000, 32'h0,        32'hCAFE_F00D, 2, 4'h0, 32'h0,        32'hCAFE_F00D};
        vt[8] = '{1'b0, 2'b00, 1'b0, 32'h0000_9002, 32'h0,        32'h007F_0000, 1, 4'h0, 32'h0,        32'h0000_007F};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_resp", {29'h0, resp_valid, resp_err, 1'b0}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;
        step();

        foreach (vt[i]) begin
            issue(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, a);
            chk("vec_bus_req", 32'(bus_req), 32'd1);
            chk("vec_stall", 32'(stall), 32'd1);
            chk("vec_bus_we", 32'(bus_we), 32'(vt[i].we));
            chk("vec_bus_addr", bus_addr, vt[i].addr & 32'hFFFF_FFFC);
            if (vt[i].we) begin
                chk("vec_bus_wstrb", 32'(bus_wstrb), 32'(vt[i].strb));
                chk("vec_bus_wdata", bus_wdata, vt[i].bwdata);
            end
            e = '{vt[i].exp_rdata, 1'b0, a + vt[i].k + 1};
            sb.push_back(e);
            ack_after(vt[i].k, vt[i].rdata);
        end

        // misaligned word load: error response, no bus traffic
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, a);
        e = '{32'h0, 1'b1, -1};
        sb.push_back(e);
        chk("misal_bus_req0", 32'(bus_req), 32'd0);
        chk("misal_stall", 32'(stall), 32'd1);
        step();
        chk("misal_bus_req1", 32'(bus_req), 32'd0);

        // timeout with no ack
        issue(1'b0, 2'b10, 1'b0, 32'h0000_A000, 32'h0, a);
        e = '{32'h0, 1'b1, a + 4};
        sb.push_back(e);
        for (int c = 0; c < 4; c++) begin
            chk("tmo_bus_req_high", 32'(bus_req), 32'd1);
            step();
        end
        chk("tmo_bus_req_low", 32'(bus_req), 32'd0);

        // ack on the final counted cycle wins over timeout
        issue(1'b0, 2'b10, 1'b0, 32'h0000_A004, 32'h0, a);
        e = '{32'h1122_3344, 1'b0, a + 4};
        sb.push_back(e);
        ack_after(3, 32'h1122_3344);

        // flush during BUSY: transaction completes, response suppressed
        issue(1'b0, 2'b10, 1'b0, 32'h0000_B000, 32'h0, a);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        ack_after(1, 32'h5555_5555);
        chk("flush_resp_valid", 32'(resp_valid), 32'd0);
        step();
        chk("flush_stall", 32'(stall), 32'd0);

        // flush during RESP
        issue(1'b0, 2'b01, 1'b0, 32'h0000_C001, 32'h0, a);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flushresp_stall", 32'(stall), 32'd0);

        // stray ack in IDLE
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        chk("idle_ack_stall", 32'(stall), 32'd0);
        chk("idle_ack_bus_req", 32'(bus_req), 32'd0);

        // reset while BUSY, then stray ack
        issue(1'b0, 2'b10, 1'b0, 32'h0000_D000, 32'h0, a);
        chk("rstbusy_bus_req", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstbusy_bus_req_drop", 32'(bus_req), 32'd0);
        chk("rstbusy_ready", 32'(req_ready), 32'd1);
        chk("rstbusy_addr", bus_addr, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        chk("rstbusy_stall", 32'(stall), 32'd0);
        chk("rstbusy_resp_rdata", resp_rdata, 32'h0);
        repeat (3) step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
